// File: rtl/asg_seq.sv
// asg_seq: steps one ASG channel through a table of waveform segments.
//
// For each table entry the sequencer writes, over a sys_bus-style master port,
// an ASG reset, then the offset, step and burst count, then a software trigger.
// It then waits for the channel's stop interrupt and moves on to the next entry.
// After the last entry it either loops back to entry 0 or ends with irq_done.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   tbl_wen/adr/dat     segment table write port (adr = {entry, field};
//                       field 0=off, 1=stp, 2=bnm, 3 ignored)
//   ctl_start/ctl_stop  start pulse (IDLE only) / abort pulse (busy only)
//   cfg_len, cfg_loop   last entry index, loop enable (sampled every cycle)
//   m_wen/addr/wdata    master write request, m_ack its acknowledge
//   irq_stp             ASG stop interrupt pulse
//   sts_busy/idx/err    status: active, current entry, sticky ack timeout
//   irq_done            one-cycle pulse when the sequence ends normally

module asg_seq #(
   parameter int unsigned SN  = 8,
   parameter int unsigned CWM = 14,
   parameter int unsigned CWF = 16,
   parameter int unsigned TMO = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tbl_wen,
   input  logic [$clog2(SN)+1:0] tbl_adr,
   input  logic [31:0]           tbl_dat,
   input  logic                  ctl_start,
   input  logic                  ctl_stop,
   input  logic [$clog2(SN)-1:0] cfg_len,
   input  logic                  cfg_loop,
   output logic                  m_wen,
   output logic [5:0]            m_addr,
   output logic [31:0]           m_wdata,
   input  logic                  m_ack,
   input  logic                  irq_stp,
   output logic                  sts_busy,
   output logic [$clog2(SN)-1:0] sts_idx,
   output logic                  sts_err,
   output logic                  irq_done
);

   localparam int unsigned IW = $clog2(SN);
   localparam int unsigned CW = CWM + CWF;
   localparam int unsigned TW = $clog2(TMO + 1);

   localparam logic [5:0] AddrCtl = 6'h00;
   localparam logic [5:0] AddrOff = 6'h14;
   localparam logic [5:0] AddrStp = 6'h18;
   localparam logic [5:0] AddrBnm = 6'h2c;

   typedef enum logic [3:0] {
      StIdle,
      StWrRst,
      StWrOff,
      StWrStp,
      StWrBnm,
      StWrTrg,
      StWait,
      StAbWait,   // abort requested, a write is still outstanding
      StAbRst     // abort: final ASG reset write
   } state_e;

   // ---------------------------------------------------------------------------
   // Segment table (not reset)
   // ---------------------------------------------------------------------------
   logic [CW-1:0] off_mem [SN];
   logic [CW-1:0] stp_mem [SN];
   logic [15:0]   bnm_mem [SN];
   logic [IW-1:0] tbl_ent;
   logic          unused_dat;

   assign tbl_ent    = tbl_adr[IW+1:2];
   assign unused_dat = ^tbl_dat;

   always_ff @(posedge clk) begin
      if (tbl_wen) begin
         case (tbl_adr[1:0])
            2'd0:    off_mem[tbl_ent] <= tbl_dat[CW-1:0];
            2'd1:    stp_mem[tbl_ent] <= tbl_dat[CW-1:0];
            2'd2:    bnm_mem[tbl_ent] <= tbl_dat[15:0];
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          m_wen_q;
   logic [5:0]    m_addr_q, wr_addr;
   logic [31:0]   m_wdata_q, wr_data;
   logic          issue;      // a new master write starts next cycle
   logic          tmo;
   logic          last_ent;

   // Timer counts cycles since the strobe; the strobe cycle itself is 0.
   assign tmo      = (tmr_q == TW'(TMO - 1)) && !m_ack;
   // A compare rather than an equality so a shrunk cfg_len still ends the run.
   assign last_ent = (idx_q >= cfg_len);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      done_d  = 1'b0;
      issue   = 1'b0;
      tmr_d   = (tmr_q != '1) ? tmr_q + TW'(1) : tmr_q;

      unique case (state_q)
         StIdle: begin
            if (ctl_start) begin
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = StWrRst;
               issue   = 1'b1;
            end
         end
         StWrRst, StWrOff, StWrStp, StWrBnm, StWrTrg: begin
            if (m_ack) begin
               issue = 1'b1;
               if (ctl_stop) begin
                  state_d = StAbRst;
               end else begin
                  case (state_q)
                     StWrRst: state_d = StWrOff;
                     StWrOff: state_d = StWrStp;
                     StWrStp: state_d = StWrBnm;
                     StWrBnm: state_d = StWrTrg;
                     default: begin
                        state_d = StWait;
                        issue   = 1'b0;
                     end
                  endcase
               end
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (ctl_stop) begin
               state_d = StAbWait;
            end
         end
         StWait: begin
            if (ctl_stop) begin
               state_d = StAbRst;
               issue   = 1'b1;
            end else if (irq_stp) begin
               if (last_ent && !cfg_loop) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  idx_d   = last_ent ? '0 : idx_q + IW'(1);
                  state_d = StWrRst;
                  issue   = 1'b1;
               end
            end
         end
         StAbWait: begin
            if (m_ack) begin
               state_d = StAbRst;
               issue   = 1'b1;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StAbRst: begin
            if (m_ack) begin
               state_d = StIdle;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (issue) tmr_d = '0;
   end

   // Address/data of the write being issued; held until the next issue.
   // Table fields are read here so late table writes are still picked up.
   always_comb begin
      wr_addr = m_addr_q;
      wr_data = m_wdata_q;
      if (issue) begin
         case (state_d)
            StWrOff: begin
               wr_addr = AddrOff;
               wr_data = 32'(off_mem[idx_d]);
            end
            StWrStp: begin
               wr_addr = AddrStp;
               wr_data = 32'(stp_mem[idx_d]);
            end
            StWrBnm: begin
               wr_addr = AddrBnm;
               wr_data = 32'(bnm_mem[idx_d]);
            end
            StWrTrg: begin
               wr_addr = AddrCtl;
               wr_data = 32'd2;
            end
            default: begin   // StWrRst and StAbRst: ASG reset
               wr_addr = AddrCtl;
               wr_data = 32'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         tmr_q     <= '0;
         m_wen_q   <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         done_q    <= done_d;
         tmr_q     <= tmr_d;
         m_wen_q   <= issue;
         m_addr_q  <= wr_addr;
         m_wdata_q <= wr_data;
      end
   end

   assign m_wen    = m_wen_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign sts_busy = (state_q != StIdle);
   assign sts_idx  = idx_q;
   assign sts_err  = err_q;
   assign irq_done = done_q;

endmodule

// File: tb/tb_asg_seq.sv
// tb_asg_seq: self-checking bench for asg_seq.
// A slave process acks master writes after a programmable latency, logs every
// write and fires irq_stp a programmable delay after each trigger write. The
// expected write stream is built from a table model: each used entry yields
// reset, off, stp, bnm, trigger.

module tb_asg_seq;

   localparam int unsigned SN  = 8;
   localparam int unsigned CWM = 14;
   localparam int unsigned CWF = 16;
   localparam int unsigned TMO = 255;
   localparam int unsigned IW  = $clog2(SN);
   localparam int unsigned AW  = IW + 2;
   localparam logic [31:0] CMASK = 32'((64'd1 << (CWM + CWF)) - 1);

   typedef logic [37:0] wr_t;   // {addr, data}

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          tbl_wen = 1'b0;
   logic [AW-1:0] tbl_adr = '0;
   logic [31:0]   tbl_dat = '0;
   logic          ctl_start = 1'b0;
   logic          ctl_stop = 1'b0;
   logic [IW-1:0] cfg_len = '0;
   logic          cfg_loop = 1'b0;
   logic          m_wen;
   logic [5:0]    m_addr;
   logic [31:0]   m_wdata;
   logic          m_ack;
   logic          irq_stp;
   logic          sts_busy;
   logic [IW-1:0] sts_idx;
   logic          sts_err;
   logic          irq_done;

   asg_seq #(.SN(SN), .CWM(CWM), .CWF(CWF), .TMO(TMO)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tbl_wen   (tbl_wen),
      .tbl_adr   (tbl_adr),
      .tbl_dat   (tbl_dat),
      .ctl_start (ctl_start),
      .ctl_stop  (ctl_stop),
      .cfg_len   (cfg_len),
      .cfg_loop  (cfg_loop),
      .m_wen     (m_wen),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_ack     (m_ack),
      .irq_stp   (irq_stp),
      .sts_busy  (sts_busy),
      .sts_idx   (sts_idx),
      .sts_err   (sts_err),
      .irq_done  (irq_done)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Table model and scoreboard
   logic [31:0]   mdl_off [SN];
   logic [31:0]   mdl_stp [SN];
   logic [31:0]   mdl_bnm [SN];
   wr_t           obs [$];
   wr_t           exp_q [$];
   logic [IW-1:0] idxs [$];

   // Slave / interrupt knobs and observations
   int ack_lat   = 1;
   int irq_dly   = 20;
   int irq_limit = 1000;
   bit irq_auto  = 1'b1;
   bit nack_stp  = 1'b0;
   bit irq_force = 1'b0;
   int ack_cnt   = 0;
   int irq_cnt   = 0;
   int irq_fired = 0;
   int irq_snap  = 0;
   int n_done    = 0;
   int stp_cyc   = 0;
   bit done_busy = 1'b0;
   bit done_prev_busy = 1'b0;
   bit busy_prev = 1'b0;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave, monitor and interrupt source, all evaluated mid-cycle.
   initial begin
      bit fire;
      m_ack   = 1'b0;
      irq_stp = 1'b0;
      forever begin
         @(negedge clk);
         m_ack = 1'b0;
         fire  = 1'b0;
         if (!rstn) begin
            ack_cnt = 0;
            irq_cnt = 0;
         end else begin
            if (ack_cnt > 0) begin
               ack_cnt--;
               if (ack_cnt == 0) m_ack = 1'b1;
            end
            if (irq_cnt > 0) begin
               irq_cnt--;
               if (irq_cnt == 0) begin
                  fire = 1'b1;
                  irq_fired++;
                  irq_snap = obs.size();
               end
            end
            if (m_wen) begin
               obs.push_back({m_addr, m_wdata});
               if (m_addr == 6'h18) stp_cyc = cyc;
               if (m_addr == 6'h00 && m_wdata == 32'd2) begin
                  idxs.push_back(sts_idx);
                  if (irq_auto && irq_fired < irq_limit) irq_cnt = irq_dly;
               end
               if (!(nack_stp && m_addr == 6'h18)) begin
                  if (ack_lat == 0) m_ack = 1'b1;
                  else ack_cnt = ack_lat;
               end
            end
            if (irq_done) begin
               n_done++;
               done_busy      = sts_busy;
               done_prev_busy = busy_prev;
            end
            busy_prev = sts_busy;
         end
         irq_stp = fire | irq_force;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Main thread lives 2 time units after each rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic tbl_wr(input int e, input int f, input logic [31:0] d);
      tbl_wen = 1'b1;
      tbl_adr = AW'(e * 4 + f);
      tbl_dat = d;
      step(1);
      tbl_wen = 1'b0;
      if (f == 0) mdl_off[e] = d & CMASK;
      if (f == 1) mdl_stp[e] = d & CMASK;
      if (f == 2) mdl_bnm[e] = d & 32'hFFFF;
   endtask

   task automatic load_rand(input int n);
      for (int e = 0; e < n; e++)
         for (int f = 0; f < 3; f++) tbl_wr(e, f, $urandom);
   endtask

   task automatic push_entry(input int e);
      exp_q.push_back({6'h00, 32'd1});
      exp_q.push_back({6'h14, mdl_off[e]});
      exp_q.push_back({6'h18, mdl_stp[e]});
      exp_q.push_back({6'h2c, mdl_bnm[e]});
      exp_q.push_back({6'h00, 32'd2});
   endtask

   task automatic clear_obs();
      obs.delete();
      exp_q.delete();
      idxs.delete();
      n_done    = 0;
      irq_fired = 0;
   endtask

   task automatic pulse_start();
      ctl_start = 1'b1;
      step(1);
      ctl_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (sts_busy && n < budget) begin
         step(1);
         n++;
      end
      check(tag, 64'(sts_busy), 64'd0);
      step(2);
   endtask

   task automatic wait_obs(input string tag, input int cnt, input int budget);
      int n = 0;
      while (obs.size() < cnt && n < budget) begin
         step(1);
         n++;
      end
      check(tag, 64'(obs.size() >= cnt), 64'd1);
   endtask

   task automatic cmp_writes(input string tag, input bit chk_size);
      wr_t got;
      if (chk_size) check({tag, "_n"}, 64'(obs.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         got = 'x;
         if (i < obs.size()) got = obs[i];
         check(tag, 64'(got), 64'(exp_q[i]));
      end
      obs.delete();
      exp_q.delete();
   endtask

   initial begin
      int n;
      int len;
      bit found;
      logic [31:0] newv;

      // Reset values
      step(2);
      check("rst_wen", 64'(m_wen), 64'd0);
      check("rst_addr", 64'(m_addr), 64'd0);
      check("rst_wdata", 64'(m_wdata), 64'd0);
      check("rst_busy", 64'(sts_busy), 64'd0);
      check("rst_idx", 64'(sts_idx), 64'd0);
      check("rst_err", 64'(sts_err), 64'd0);
      check("rst_done", 64'(irq_done), 64'd0);
      rstn = 1'b1;
      step(2);

      // Single entry, one-cycle slave, irq 20 cycles after trigger
      tbl_wr(0, 0, 32'd0);
      tbl_wr(0, 1, 32'h10000);
      tbl_wr(0, 2, 32'd3);
      cfg_len = 0;
      cfg_loop = 1'b0;
      clear_obs();
      pulse_start();
      wait_idle("t1_idle", 400);
      exp_q.push_back({6'h00, 32'd1});
      exp_q.push_back({6'h14, 32'd0});
      exp_q.push_back({6'h18, 32'h10000});
      exp_q.push_back({6'h2c, 32'd3});
      exp_q.push_back({6'h00, 32'd2});
      cmp_writes("t1_wr", 1'b1);
      check("t1_done_cnt", 64'(n_done), 64'd1);
      check("t1_busy_at_done", 64'(done_busy), 64'd0);
      check("t1_busy_before_done", 64'(done_prev_busy), 64'd1);

      // Looping over three entries, four stop interrupts
      load_rand(3);
      cfg_len = 2;
      cfg_loop = 1'b1;
      irq_limit = 4;
      clear_obs();
      pulse_start();
      n = 0;
      while (irq_fired < 4 && n < 2000) begin
         step(1);
         n++;
      end
      step(3);
      check("t2_irq_cnt", 64'(irq_fired), 64'd4);
      check("t2_nwr", 64'(irq_snap), 64'd20);
      check("t2_done_cnt", 64'(n_done), 64'd0);
      for (int i = 0; i < 4; i++) check("t2_idx", 64'(idxs[i]), 64'(i % 3));
      push_entry(0);
      push_entry(1);
      push_entry(2);
      push_entry(0);
      cmp_writes("t2_wr", 1'b0);
      ctl_stop = 1'b1;
      step(1);
      ctl_stop = 1'b0;
      wait_idle("t2_idle", 600);
      irq_limit = 1000;
      cfg_loop = 1'b0;

      // Slave never acks the step write
      cfg_len = 0;
      nack_stp = 1'b1;
      clear_obs();
      pulse_start();
      n = 0;
      while (!sts_err && n < 600) begin
         step(1);
         n++;
      end
      check("t3_err", 64'(sts_err), 64'd1);
      check("t3_tmo_cycles", 64'(cyc - stp_cyc), 64'd255);
      check("t3_busy", 64'(sts_busy), 64'd0);
      step(2);
      check("t3_done_cnt", 64'(n_done), 64'd0);
      check("t3_nwr", 64'(obs.size()), 64'd3);
      nack_stp = 1'b0;
      clear_obs();
      pulse_start();
      check("t3_err_clr", 64'(sts_err), 64'd0);
      check("t3_busy_again", 64'(sts_busy), 64'd1);
      wait_idle("t3_idle", 400);
      check("t3_done_again", 64'(n_done), 64'd1);

      // ctl_stop and irq_stp together while waiting
      load_rand(2);
      cfg_len = 1;
      irq_auto = 1'b0;
      clear_obs();
      pulse_start();
      wait_obs("t4_trg_seen", 5, 200);
      step(4);
      check("t4_in_wait", 64'(sts_busy), 64'd1);
      obs.delete();
      ctl_stop = 1'b1;
      irq_force = 1'b1;
      step(1);
      ctl_stop = 1'b0;
      irq_force = 1'b0;
      wait_idle("t4_idle", 400);
      exp_q.push_back({6'h00, 32'd1});
      cmp_writes("t4_wr", 1'b1);
      check("t4_done_cnt", 64'(n_done), 64'd0);
      check("t4_idx", 64'(sts_idx), 64'd0);
      irq_auto = 1'b1;

      // Reset while the offset write is being strobed
      ack_lat = 2;
      cfg_len = 0;
      clear_obs();
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (m_wen && m_addr == 6'h14) found = 1'b1;
      end
      check("t5_off_strobe", 64'(found), 64'd1);
      #1 rstn = 1'b0;
      #1;
      check("t5_wen_async", 64'(m_wen), 64'd0);
      check("t5_busy_async", 64'(sts_busy), 64'd0);
      step(2);
      rstn = 1'b1;
      obs.delete();
      step(20);
      check("t5_no_writes", 64'(obs.size()), 64'd0);
      check("t5_busy_after", 64'(sts_busy), 64'd0);
      ack_lat = 1;

      // Table update to entry 1 while entry 0 is running
      load_rand(2);
      cfg_len = 1;
      clear_obs();
      pulse_start();
      wait_obs("t6_trg_seen", 5, 200);
      newv = $urandom;
      tbl_wr(1, 1, newv);
      wait_idle("t6_idle", 400);
      push_entry(0);
      push_entry(1);
      cmp_writes("t6_wr", 1'b1);
      check("t6_done_cnt", 64'(n_done), 64'd1);

      // cfg_len shrunk below the current entry ends at the next interrupt
      load_rand(4);
      cfg_len = 3;
      clear_obs();
      pulse_start();
      n = 0;
      while (idxs.size() < 3 && n < 600) begin
         step(1);
         n++;
      end
      cfg_len = 1;
      wait_idle("t7_idle", 600);
      push_entry(0);
      push_entry(1);
      push_entry(2);
      cmp_writes("t7_wr", 1'b1);
      check("t7_done_cnt", 64'(n_done), 64'd1);
      check("t7_idx", 64'(sts_idx), 64'd2);

      // Randomized runs: table contents, length, ack latency, irq delay
      for (int it = 0; it < 6; it++) begin
         ack_lat = $urandom_range(0, 3);
         irq_dly = $urandom_range(ack_lat + 3, 25);
         len     = $urandom_range(0, SN - 1);
         load_rand(len + 1);
         cfg_len = IW'(len);
         clear_obs();
         pulse_start();
         wait_idle("rnd_idle", 3000);
         for (int e = 0; e <= len; e++) push_entry(e);
         cmp_writes("rnd_wr", 1'b1);
         check("rnd_done_cnt", 64'(n_done), 64'd1);
         check("rnd_err", 64'(sts_err), 64'd0);
         check("rnd_idx", 64'(sts_idx), 64'(len));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
